context_unshuffler: RTL and testbench

// Decoder-side counterpart of the encoder context/quotient stage. Takes one
// 8-pixel group of Golomb fields per cycle: sign s, quotient high qh, quotient
// low ql, and a 2-bit state st per position. Rebuilds the combined context

---
 rtl/context_unshuffler.sv | 179 +++++++++++++++++
 tb/tb_context_unshuffler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/context_unshuffler.sv
// Decoder-side context/quotient stage: rebuilds the context index from Golomb
// fields, strips the neighbour context derived from the upper row and reconstructs x.
module context_unshuffler #(
    parameter int QDIV = 13,
    parameter int LAT  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            i_sp,
    input  logic            i_vl,
    input  logic [1:8][1:0] i_st,
    input  logic [0:9][7:0] i_b,
    input  logic [1:8]      i_s,
    input  logic [1:8][4:0] i_qh,
    input  logic [1:8][3:0] i_ql,
    input  logic [1:8][7:0] i_raw,
    output logic            o_sp,
    output logic            o_vl,
    output logic [0:7][7:0] o_x,
    output logic [1:8]      o_err
);

    typedef enum logic [1:0] {
        ST_REGULAR = 2'd0,
        ST_RUN     = 2'd1,
        ST_RUN_INT = 2'd2,
        ST_ESCAPE  = 2'd3
    } state_e;

    // Per-position fields that ride along unchanged until reconstruction.
    typedef struct packed {
        state_e     st;
        logic [1:0] ri;
        logic [7:0] c;
        logic [7:0] raw;
    } lane_t;

    function automatic logic signed [9:0] quant(input logic [7:0] a, input logic [7:0] c);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, c});
        if (d <= -9'sd21)      return -10'sd4;
        else if (d <= -9'sd7)  return -10'sd3;
        else if (d <= -9'sd3)  return -10'sd2;
        else if (d < 9'sd0)    return -10'sd1;
        else if (d == 9'sd0)   return 10'sd0;
        else if (d < 9'sd3)    return 10'sd1;
        else if (d < 9'sd7)    return 10'sd2;
        else if (d < 9'sd21)   return 10'sd3;
        else                   return 10'sd4;
    endfunction

    function automatic logic signed [9:0] rmap(input logic signed [10:0] qb);
        case (qb)
            11'sd1:  return 10'sd1;
            11'sd2:  return 10'sd4;
            11'sd3:  return 10'sd13;
            11'sd4:  return 10'sd24;
            -11'sd1: return -10'sd1;
            -11'sd2: return -10'sd4;
            -11'sd3: return -10'sd13;
            -11'sd4: return -10'sd24;
            default: return 10'sd0;
        endcase
    endfunction

    logic [LAT-2:0] sp_pipe, vl_pipe;

    logic [8:0]        q_n   [1:8];
    logic signed [9:0] qa_n  [1:8];
    lane_t             ln_n  [1:8];
    logic [8:0]        sa_q  [1:8];
    logic signed [9:0] sa_qa [1:8];
    logic              sa_s  [1:8];
    logic [3:0]        sa_ql [1:8];
    lane_t             sa_ln [1:8];

    logic signed [10:0] qb_n   [1:8];
    logic               errb_n [1:8];
    logic signed [10:0] sb_qb  [1:8];
    logic               sb_err [1:8];
    lane_t              sb_ln  [1:8];

    logic [7:0] x_n    [1:8];
    logic       errc_n [1:8];
    logic [7:0] sc_x   [1:8];
    logic       sc_err [1:8];

    // Stage A: quotient and neighbour context.
    always_comb begin
        for (int i = 1; i <= 8; i++) begin
            q_n[i]  = 9'(i_qh[i]) * 9'(QDIV) + 9'(i_ql[i]);
            qa_n[i] = 10'sd81 * quant(i_b[i+1], i_b[i]) + 10'sd9 * quant(i_b[i], i_b[i-1]);
            ln_n[i] = '{st: state_e'(i_st[i]), ri: i_qh[i][1:0], c: i_b[i-1], raw: i_raw[i]};
        end
    end

    // Stage B: signed context, gradient bin, regular-mode error. qb is one bit
    // wider than qs so out-of-range bins cannot wrap back into -4..4.
    always_comb begin
        logic signed [9:0] qs;
        for (int i = 1; i <= 8; i++) begin
            qs = $signed({1'b0, sa_q[i]}) + 10'sd1;
            if (sa_s[i]) qs = -qs;
            qb_n[i]   = {qs[9], qs} - {sa_qa[i][9], sa_qa[i]};
            errb_n[i] = (sa_ln[i].st == ST_REGULAR) &&
                        (sa_ql[i] > 4'd12 || qb_n[i] < -11'sd4 || qb_n[i] > 11'sd4);
        end
    end

    // Stage C: reconstruction.
    always_comb begin
        logic signed [9:0] xs;
        for (int i = 1; i <= 8; i++) begin
            // NOTE: every output gets a default before the case so no path infers a latch.
            x_n[i]    = sb_ln[i].c;
            errc_n[i] = sb_err[i];
            xs        = $signed({2'b00, sb_ln[i].c}) - rmap(sb_qb[i]);
            case (sb_ln[i].st)
                ST_REGULAR: begin
                    if (!sb_err[i]) begin
                        if (xs < 10'sd0)        x_n[i] = 8'd0;
                        else if (xs > 10'sd255) x_n[i] = 8'd255;
                        else                    x_n[i] = xs[7:0];
                    end
                end
                ST_RUN_INT: begin
                    case (sb_ln[i].ri)
                        2'b10:   x_n[i] = (sb_ln[i].c == 8'd255) ? 8'd255 : sb_ln[i].c + 8'd1;
                        2'b00:   x_n[i] = (sb_ln[i].c == 8'd0) ? 8'd0 : sb_ln[i].c - 8'd1;
                        2'b11:   errc_n[i] = 1'b1;
                        default: ;
                    endcase
                end
                ST_ESCAPE: x_n[i] = sb_ln[i].raw;
                default:   ;
            endcase
        end
    end

    // NOTE: pipeline data registers carry no reset; only flags and outputs do.
    always_ff @(posedge clk) begin
        if (ena) begin
            for (int i = 1; i <= 8; i++) begin
                sa_q[i]   <= q_n[i];
                sa_qa[i]  <= qa_n[i];
                sa_s[i]   <= i_s[i];
                sa_ql[i]  <= i_ql[i];
                sa_ln[i]  <= ln_n[i];
                sb_qb[i]  <= qb_n[i];
                sb_err[i] <= errb_n[i];
                sb_ln[i]  <= sa_ln[i];
                sc_x[i]   <= x_n[i];
                sc_err[i] <= errc_n[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_pipe <= '0;
            vl_pipe <= '0;
            o_sp    <= 1'b0;
            o_vl    <= 1'b0;
            o_err   <= '0;
            o_x     <= '0;
        end else if (ena) begin
            sp_pipe <= {sp_pipe[LAT-3:0], i_sp};
            vl_pipe <= {vl_pipe[LAT-3:0], i_vl};
            o_sp    <= sp_pipe[LAT-2];
            o_vl    <= vl_pipe[LAT-2];
            for (int i = 1; i <= 8; i++) begin
                o_x[i-1] <= sc_x[i];
                o_err[i] <= sc_err[i] & vl_pipe[LAT-2];
            end
        end
    end

endmodule

// File: tb/tb_context_unshuffler.sv
// Randomized scoreboard bench for context_unshuffler: a driver pushes modelled
// results, a monitor pops and compares on every ena-qualified output update.
module tb_context_unshuffler;

    localparam int LAT = 4;
    localparam int R_TAB [9] = '{-24, -13, -4, -1, 0, 1, 4, 13, 24};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ena = 1'b0;
    logic            i_sp = 1'b0;
    logic            i_vl = 1'b0;
    logic [1:8][1:0] i_st = '0;
    logic [0:9][7:0] i_b = '0;
    logic [1:8]      i_s = '0;
    logic [1:8][4:0] i_qh = '0;
    logic [1:8][3:0] i_ql = '0;
    logic [1:8][7:0] i_raw = '0;
    logic            o_sp, o_vl;
    logic [0:7][7:0] o_x;
    logic [1:8]      o_err;

    context_unshuffler #(.QDIV(13), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .ena(ena), .i_sp(i_sp), .i_vl(i_vl),
        .i_st(i_st), .i_b(i_b), .i_s(i_s), .i_qh(i_qh), .i_ql(i_ql), .i_raw(i_raw),
        .o_sp(o_sp), .o_vl(o_vl), .o_x(o_x), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            sp;
        logic            vl;
        logic [1:8][1:0] st;
        logic [0:9][7:0] b;
        logic [1:8]      s;
        logic [1:8][4:0] qh;
        logic [1:8][3:0] ql;
        logic [1:8][7:0] raw;
    } grp_t;

    typedef struct {
        logic            sp;
        logic            vl;
        logic            chk_x;
        logic [0:7][7:0] x;
        logic [1:8]      err;
        int              dir_x0;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int quant_m(input int d);
        if (d <= -21) return -4;
        if (d <= -7)  return -3;
        if (d <= -3)  return -2;
        if (d < 0)    return -1;
        if (d == 0)   return 0;
        if (d < 3)    return 1;
        if (d < 7)    return 2;
        if (d < 21)   return 3;
        return 4;
    endfunction

    function automatic int qa_m(input grp_t g, input int i);
        return 81 * quant_m(int'(g.b[i+1]) - int'(g.b[i])) + 9 * quant_m(int'(g.b[i]) - int'(g.b[i-1]));
    endfunction

    // Reference decoder: plain integer arithmetic straight from the decoding rules.
    function automatic exp_t model(input grp_t g, input int dir_x0);
        exp_t e;
        e.sp = g.sp; e.vl = g.vl; e.chk_x = g.vl; e.dir_x0 = dir_x0;
        e.x = '0; e.err = '0;
        for (int i = 1; i <= 8; i++) begin
            int c, x, q, qs, qb;
            bit err;
            c = int'(g.b[i-1]); x = c; err = 0;
            case (g.st[i])
                2'd0: begin
                    q  = int'(g.qh[i]) * 13 + int'(g.ql[i]);
                    qs = g.s[i] ? -(q + 1) : (q + 1);
                    qb = qs - qa_m(g, i);
                    err = (g.ql[i] > 12) || (qb < -4) || (qb > 4);
                    if (!err) begin
                        x = c - R_TAB[qb + 4];
                        if (x < 0) x = 0;
                        if (x > 255) x = 255;
                    end
                end
                2'd1: x = c;
                2'd2: begin
                    case (g.qh[i][1:0])
                        2'b01: x = c;
                        2'b10: x = (c < 255) ? c + 1 : 255;
                        2'b00: x = (c > 0) ? c - 1 : 0;
                        default: err = 1;
                    endcase
                end
                default: x = int'(g.raw[i]);
            endcase
            e.x[i-1] = 8'(x);
            e.err[i] = err & g.vl;
        end
        return e;
    endfunction

    function automatic grp_t flat_grp(input int bval);
        grp_t g;
        g.sp = 0; g.vl = 1; g.st = '0; g.s = '0; g.qh = '0; g.ql = '0; g.raw = '0;
        for (int k = 0; k <= 9; k++) g.b[k] = 8'(bval);
        return g;
    endfunction

    function automatic grp_t rand_grp();
        grp_t g;
        int v, r, qs, q;
        g.sp = ($urandom_range(0, 15) == 0);
        g.vl = ($urandom_range(0, 7) != 0);
        g.b[0] = 8'($urandom_range(0, 255));
        for (int k = 1; k <= 9; k++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 255));
                1: v = int'(g.b[k-1]) + int'($urandom_range(0, 50)) - 25;
                2: v = int'(g.b[k-1]);
                default: v = int'(g.b[k-1]) + int'($urandom_range(0, 6)) - 3;
            endcase
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            g.b[k] = 8'(v);
        end
        for (int i = 1; i <= 8; i++) begin
            r = int'($urandom_range(0, 7));
            g.st[i]  = (r < 4) ? 2'd0 : 2'(r - 4);
            g.s[i]   = 1'($urandom_range(0, 1));
            g.qh[i]  = 5'($urandom_range(0, 31));
            g.ql[i]  = 4'($urandom_range(0, 15));
            g.raw[i] = 8'($urandom_range(0, 255));
            // Mostly aim regular positions at a legal bin so reconstruction is exercised.
            if (g.st[i] == 2'd0 && $urandom_range(0, 3) != 0) begin
                qs = int'($urandom_range(0, 8)) - 4 + qa_m(g, i);
                if (qs == 0) qs = 1;
                g.s[i] = (qs < 0);
                q = (qs > 0) ? qs - 1 : -qs - 1;
                g.qh[i] = 5'(q / 13);
                g.ql[i] = 4'(q % 13);
            end
        end
        return g;
    endfunction

    task automatic drive(input grp_t g, input logic en, input logic r, input int dir_x0);
        @(negedge clk);
        rst = r; ena = en;
        i_sp = g.sp; i_vl = g.vl; i_st = g.st; i_b = g.b;
        i_s = g.s; i_qh = g.qh; i_ql = g.ql; i_raw = g.raw;
        if (en && !r) sb_q.push_back(model(g, dir_x0));
    endtask

    task automatic compare(input string tag, input exp_t e);
        check({tag, "_o_vl"}, 64'(o_vl), 64'(e.vl));
        check({tag, "_o_sp"}, 64'(o_sp), 64'(e.sp));
        check({tag, "_o_err"}, 64'(o_err), 64'(e.err));
        if (e.chk_x) check({tag, "_o_x"}, o_x, e.x);
        if (e.dir_x0 >= 0) check({tag, "_o_x0_directed"}, 64'(o_x[0]), 64'(e.dir_x0));
    endtask

    // Monitor: one pop per ena-qualified edge, hold check on stalled edges.
    initial begin
        exp_t e, last, bubble;
        logic s_rst, s_ena;
        bubble = '{sp: 1'b0, vl: 1'b0, chk_x: 1'b0, x: '0, err: '0, dir_x0: -1};
        last = bubble;
        forever begin
            @(posedge clk);
            s_rst = rst; s_ena = ena;
            #1;
            if (s_rst) begin
                check("rst_o_vl", 64'(o_vl), 64'd0);
                check("rst_o_sp", 64'(o_sp), 64'd0);
                check("rst_o_err", 64'(o_err), 64'd0);
                check("rst_o_x", o_x, 64'd0);
                sb_q.delete();
                repeat (LAT - 1) sb_q.push_back(bubble);
                last = bubble;
                last.chk_x = 1'b1;
            end else if (s_ena) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL scoreboard_underflow: got empty queue expected an entry");
                end else begin
                    e = sb_q.pop_front();
                    compare("out", e);
                    last = e;
                end
            end else begin
                compare("hold", last);
            end
        end
    end

    initial begin
        grp_t g;
        int r;
        repeat (3) drive(flat_grp(0), 1'b1, 1'b1, -1);

        // Directed: flat rows, sign/quotient variants, clamps, errors.
        g = flat_grp(100); g.sp = 1;                       drive(g, 1'b1, 1'b0, 99);
        g = flat_grp(100); g.s[1] = 1;                     drive(g, 1'b1, 1'b0, 101);
        g = flat_grp(100); g.ql[1] = 3;                    drive(g, 1'b1, 1'b0, 76);
        g = flat_grp(100); g.b[2] = 130; g.qh[1] = 24; g.ql[1] = 11;
        drive(g, 1'b1, 1'b0, 100);
        g = flat_grp(250); g.s[1] = 1; g.ql[1] = 3;        drive(g, 1'b1, 1'b0, 255);
        g = flat_grp(5); g.ql[1] = 3;                      drive(g, 1'b1, 1'b0, 0);
        g = flat_grp(100); g.ql[1] = 4; g.ql[2] = 13;      drive(g, 1'b1, 1'b0, 100);

        // Directed: run, run-interrupt variants at range edges, escape.
        g = flat_grp(0);
        for (int k = 0; k <= 9; k++) g.b[k] = 8'(k * 20);
        g.b[3] = 8'd0; g.b[6] = 8'd255;
        g.st[1] = 2'd1;
        g.st[2] = 2'd2; g.qh[2] = 5'b00001;
        g.st[3] = 2'd2; g.qh[3] = 5'b00010;
        g.st[4] = 2'd2; g.qh[4] = 5'b00000;
        g.st[5] = 2'd2; g.qh[5] = 5'b00011;
        g.st[6] = 2'd3; g.raw[6] = 8'hA5;
        g.st[7] = 2'd2; g.qh[7] = 5'b11110;
        drive(g, 1'b1, 1'b0, 0);

        repeat (4) begin g = rand_grp(); g.vl = 0; drive(g, 1'b1, 1'b0, -1); end

        // Stall mid-flight, then reset while group 3 is in the pipe.
        g = rand_grp(); g.vl = 1; drive(g, 1'b1, 1'b0, -1);
        g = rand_grp(); g.vl = 1; drive(g, 1'b1, 1'b0, -1);
        repeat (2) begin g = rand_grp(); g.vl = 1; drive(g, 1'b0, 1'b0, -1); end
        g = rand_grp(); g.vl = 1; drive(g, 1'b1, 1'b0, -1);
        g = rand_grp(); g.vl = 1; drive(g, 1'b1, 1'b0, -1);
        g = rand_grp(); g.vl = 1; drive(g, 1'b1, 1'b1, -1);
        repeat (2) begin g = rand_grp(); drive(g, 1'b0, 1'b0, -1); end

        // Random traffic with occasional stalls and resets.
        repeat (400) begin
            r = int'($urandom_range(0, 99));
            drive(rand_grp(), (r >= 10) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, -1);
        end
        repeat (LAT + 2) begin g = rand_grp(); g.vl = 0; drive(g, 1'b1, 1'b0, -1); end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
